// File: rtl/hash_req_arbiter.sv
// Round-robin front-end sharing one hash core among N_REQ byte-stream requesters.
// One requester is granted per message; its length and bytes go to the core, and
// the digest comes back tagged with the requester index.
module hash_req_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*64-1:0]  req_len,
  output logic [N_REQ-1:0]     req_ack,
  input  logic [N_REQ*8-1:0]   s_data,
  input  logic [N_REQ-1:0]     s_valid,
  output logic [N_REQ-1:0]     s_ready,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [31:0]          rsp_digest,
  output logic                 busy,
  output logic                 core_m_valid,
  output logic [63:0]          core_c_in,
  output logic [7:0]           core_m,
  input  logic                 core_hash_ready,
  input  logic [31:0]          core_digest
);

  localparam int unsigned LEN_W = 64;
  localparam int unsigned DIG_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_WAIT   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    gnt_q, gnt_d;
  logic [ID_W-1:0]    prio_q, prio_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [DIG_W-1:0]   rsp_dig_q, rsp_dig_d;
  logic               busy_q, busy_d;

  logic [LEN_W-1:0]   len_arr  [N_REQ];
  logic [7:0]         data_arr [N_REQ];

  logic               pick_found;
  logic [ID_W-1:0]    pick_idx;
  int unsigned        cand;
  logic [ID_W-1:0]    cand_id;
  logic               streaming;

  // Unpack the flat per-requester buses.
  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign len_arr[i]  = req_len[LEN_W*i +: LEN_W];
    assign data_arr[i] = s_data[8*i +: 8];
  end

  // First pending requester at or after prio, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_id    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand    = (32'(prio_q) + k) % N_REQ;
      cand_id = ID_W'(cand);
      if (!pick_found && req_valid[cand_id]) begin
        pick_found = 1'b1;
        pick_idx   = cand_id;
      end
    end
  end

  // Byte-path handshake and core drive; zero-length messages send one dummy init beat.
  always_comb begin
    streaming    = (state_q == ST_STREAM);
    s_ready      = '0;
    core_m_valid = 1'b0;
    core_m       = 8'h00;
    if (streaming) begin
      if (rem_q != '0) begin
        s_ready[gnt_q] = 1'b1;
        core_m_valid   = s_valid[gnt_q];
        core_m         = data_arr[gnt_q];
      end else begin
        core_m_valid   = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    prio_d      = prio_q;
    rem_d       = rem_q;
    len_d       = len_q;
    ack_d       = '0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_dig_d   = rsp_dig_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          gnt_d           = pick_idx;
          rem_d           = len_arr[pick_idx];
          len_d           = len_arr[pick_idx];
          ack_d[pick_idx] = 1'b1;
          state_d         = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (rem_q == '0) begin
          state_d = ST_WAIT;
        end else if (s_valid[gnt_q]) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (core_hash_ready) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = gnt_q;
          rsp_dig_d   = core_digest;
          prio_d      = (gnt_q == ID_W'(N_REQ - 1)) ? '0 : gnt_q + ID_W'(1);
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      prio_q      <= '0;
      rem_q       <= '0;
      len_q       <= '0;
      ack_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_dig_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      prio_q      <= prio_d;
      rem_q       <= rem_d;
      len_q       <= len_d;
      ack_q       <= ack_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_dig_q   <= rsp_dig_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ack    = ack_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_digest = rsp_dig_q;
  assign busy       = busy_q;
  assign core_c_in  = len_q;

endmodule

// File: tb/tb_hash_req_arbiter.sv
// Bench for hash_req_arbiter: emulates the hash core and requesters, and checks
// every cycle against a message-level reference model.
module tb_hash_req_arbiter;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*64-1:0] req_len;
  logic [N-1:0]    req_ack;
  logic [N*8-1:0]  s_data;
  logic [N-1:0]    s_valid;
  logic [N-1:0]    s_ready;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [31:0]     rsp_digest;
  logic            busy;
  logic            core_m_valid;
  logic [63:0]     core_c_in;
  logic [7:0]      core_m;
  logic            core_hash_ready;
  logic [31:0]     core_digest;

  always #5 clk = ~clk;

  hash_req_arbiter #(.N_REQ(4), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_len(req_len), .req_ack(req_ack),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_digest(rsp_digest),
    .busy(busy), .core_m_valid(core_m_valid), .core_c_in(core_c_in), .core_m(core_m),
    .core_hash_ready(core_hash_ready), .core_digest(core_digest)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // reference model
  int          m_state;   // 0 idle, 1 stream, 2 wait
  logic [1:0]  m_gnt, m_prio, m_rsp_id;
  logic [63:0] m_rem, m_len;
  logic [N-1:0] m_ack;
  bit          m_rsp_v;
  logic [31:0] m_rsp_dig, m_h;

  // requesters
  bit          want [N];
  logic [63:0] wlen [N];
  int          acc  [N];
  int          rep  [N];
  bit          rnd_mode = 0;
  bit          spawn = 0;
  bit          svq[$];

  // core emulation
  bit          c_active;
  int          c_pend;
  logic [63:0] c_len, c_cnt;
  logic [31:0] c_h;

  // pre-edge samples
  logic [N-1:0]    pv_rv, pv_sv;
  logic [N*64-1:0] pv_rl;
  logic [N*8-1:0]  pv_sd;
  logic            pv_hr, pv_mv;
  logic [7:0]      pv_m;
  logic [63:0]     pv_cin;

  // observed DUT events
  int          ack_c[$], ack_i[$], rsp_c[$], rsp_i[$];
  logic [31:0] rsp_d[$];
  int          beats;
  logic [63:0] last_cin;
  logic [N-1:0] sr_seen;

  function automatic logic [31:0] fnv(input logic [31:0] h, input logic [7:0] b);
    return (h ^ {24'h0, b}) * 32'h0100_0193;
  endfunction

  function automatic logic [31:0] seed(input logic [63:0] len);
    return 32'h811c_9dc5 ^ len[31:0] ^ len[63:32];
  endfunction

  function automatic logic [31:0] golden_abc(input int n);
    logic [31:0] h;
    h = seed(64'(n));
    for (int i = 0; i < n; i++) h = fnv(h, 8'(8'h61 + i));
    return h;
  endfunction

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic logic [31:0] dget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 'x;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_gnt = 0; m_prio = 0; m_rsp_id = 0;
    m_rem = 0; m_len = 0; m_ack = 0; m_rsp_v = 0; m_rsp_dig = 0; m_h = 0;
  endtask

  task automatic core_reset();
    c_active = 0; c_pend = 0; c_len = 0; c_cnt = 0; c_h = 0;
    core_hash_ready = 1'b0; core_digest = 32'h0;
  endtask

  task automatic clear_logs();
    ack_c.delete(); ack_i.delete(); rsp_c.delete(); rsp_i.delete(); rsp_d.delete();
    beats = 0; last_cin = 0; sr_seen = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (m_ack[i]) begin
        if (rep[i] > 0) rep[i]--;
        else want[i] = 0;
      end
      if (rnd_mode && !want[i]) begin
        wlen[i] = 64'($urandom_range(0, 6));
        if (spawn && $urandom_range(0, 3) == 0) want[i] = 1;
      end
      req_valid[i] = want[i];
      req_len[64*i +: 64] = wlen[i];
      if (rnd_mode) begin
        s_valid[i] = ($urandom_range(0, 3) != 0);
        s_data[8*i +: 8] = 8'($urandom);
      end else begin
        s_valid[i] = 1'b1;
        s_data[8*i +: 8] = 8'(8'h61 + acc[i]);
      end
    end
    if (!rnd_mode && svq.size() > 0 && m_state == 1) begin
      bit b;
      b = svq.pop_front();
      s_valid = {N{b}};
    end
  endtask

  task automatic compare();
    logic [N-1:0] e_sr;
    logic         e_mv;
    logic [7:0]   e_m;
    bit           strm;
    strm = (m_state == 1);
    e_sr = '0;
    if (strm && m_rem != 0) e_sr[m_gnt] = 1'b1;
    e_mv = strm && (m_rem == 0 || s_valid[m_gnt]);
    e_m  = (strm && m_rem != 0) ? s_data[8*m_gnt +: 8] : 8'h00;
    check("busy",       64'(busy),         64'(m_state != 0));
    check("req_ack",    64'(req_ack),      64'(m_ack));
    check("s_ready",    64'(s_ready),      64'(e_sr));
    check("core_m_valid", 64'(core_m_valid), 64'(e_mv));
    check("core_m",     64'(core_m),       64'(e_m));
    check("core_c_in",  core_c_in,         m_len);
    check("rsp_valid",  64'(rsp_valid),    64'(m_rsp_v));
    check("rsp_id",     64'(rsp_id),       64'(m_rsp_id));
    check("rsp_digest", 64'(rsp_digest),   64'(m_rsp_dig));
  endtask

  task automatic record();
    for (int i = 0; i < N; i++)
      if (req_ack[i]) begin ack_c.push_back(cyc); ack_i.push_back(i); end
    if (rsp_valid) begin
      rsp_c.push_back(cyc); rsp_i.push_back(int'(rsp_id)); rsp_d.push_back(rsp_digest);
    end
    if (core_m_valid) begin beats++; last_cin = core_c_in; end
    sr_seen |= s_ready;
  endtask

  task automatic model_step();
    int idx;
    if (!rst_n) begin model_reset(); return; end
    m_ack = '0;
    m_rsp_v = 0;
    case (m_state)
      0: begin
        for (int k = 0; k < N; k++) begin
          idx = (int'(m_prio) + k) % N;
          if (pv_rv[idx]) begin
            m_gnt = 2'(idx);
            m_len = pv_rl[64*idx +: 64];
            m_rem = m_len;
            m_h = seed(m_len);
            m_ack[idx] = 1'b1;
            acc[idx] = 0;
            m_state = 1;
            break;
          end
        end
      end
      1: begin
        if (m_rem == 0) m_state = 2;
        else if (pv_sv[m_gnt]) begin
          m_h = fnv(m_h, pv_sd[8*m_gnt +: 8]);
          acc[m_gnt]++;
          m_rem = m_rem - 64'd1;
          if (m_rem == 0) m_state = 2;
        end
      end
      default: begin
        if (pv_hr) begin
          m_rsp_v = 1;
          m_rsp_id = m_gnt;
          m_rsp_dig = m_h;
          m_prio = 2'((int'(m_gnt) + 1) % N);
          m_state = 0;
        end
      end
    endcase
  endtask

  // Core: init beat clears hash_ready; ready rises 3 cycles after the last data beat
  // (2 after the lone beat of a zero-length message) and stays high until the next init.
  task automatic core_step();
    if (!rst_n) begin core_reset(); return; end
    if (pv_mv) begin
      if (!c_active) begin
        c_len = pv_cin; c_h = seed(pv_cin); c_cnt = 0; c_pend = 0;
        core_hash_ready = 1'b0;
        if (pv_cin == 0) c_pend = 1;
        else begin
          c_h = fnv(c_h, pv_m); c_cnt = 1;
          if (c_cnt == c_len) c_pend = 2; else c_active = 1;
        end
      end else begin
        c_h = fnv(c_h, pv_m); c_cnt++;
        if (c_cnt == c_len) begin c_active = 0; c_pend = 2; end
      end
    end else if (c_pend > 0) begin
      c_pend--;
      if (c_pend == 0) core_hash_ready = 1'b1;
    end
    core_digest = core_hash_ready ? c_h : $urandom;
  endtask

  task automatic tick();
    drive();
    #1;
    compare();
    record();
    pv_rv = req_valid; pv_rl = req_len; pv_sv = s_valid; pv_sd = s_data;
    pv_hr = core_hash_ready; pv_mv = core_m_valid; pv_m = core_m; pv_cin = core_c_in;
    @(posedge clk);
    #1;
    model_step();
    core_step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    core_reset();
    for (int i = 0; i < N; i++) begin want[i] = 0; rep[i] = 0; acc[i] = 0; end
    svq.delete();
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  function automatic bit any_want();
    for (int i = 0; i < N; i++) if (want[i]) return 1;
    return 0;
  endfunction

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((m_state != 0 || any_want()) && n < maxc) begin tick(); n++; end
    check("drain_timeout", 64'(n >= maxc), 64'd0);
    repeat (2) tick();
  endtask

  initial begin
    int start, d0, d1;
    logic [31:0] dig0;
    rst_n = 1'b0;
    req_valid = '0; req_len = '0; s_valid = '0; s_data = '0;
    for (int i = 0; i < N; i++) begin want[i] = 0; wlen[i] = 0; acc[i] = 0; rep[i] = 0; end
    model_reset();
    core_reset();
    clear_logs();
    @(negedge clk);
    do_reset(3);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_rsp_digest", 64'(rsp_digest), 64'd0);

    // single message: req 0, len 3, bytes 61 62 63
    clear_logs(); start = cyc;
    want[0] = 1; wlen[0] = 3;
    drain(40);
    check("t1_nack", 64'(ack_c.size()), 64'd1);
    check("t1_ack_cyc", 64'(qget(ack_c, 0) - start), 64'd1);
    check("t1_ack_id", 64'(qget(ack_i, 0)), 64'd0);
    check("t1_beats", 64'(beats), 64'd3);
    check("t1_cin", last_cin, 64'd3);
    check("t1_rsp_lat", 64'(qget(rsp_c, 0) - qget(ack_c, 0)), 64'd6);
    check("t1_rsp_id", 64'(qget(rsp_i, 0)), 64'd0);
    check("t1_digest", 64'(dget(rsp_d, 0)), 64'(golden_abc(3)));

    // zero length on requester 2
    clear_logs();
    want[2] = 1; wlen[2] = 0;
    drain(40);
    check("t2_beats", 64'(beats), 64'd1);
    check("t2_cin", last_cin, 64'd0);
    check("t2_no_sready", 64'(sr_seen[2]), 64'd0);
    check("t2_rsp_lat", 64'(qget(rsp_c, 0) - qget(ack_c, 0)), 64'd3);
    check("t2_rsp_id", 64'(qget(rsp_i, 0)), 64'd2);
    check("t2_digest", 64'(dget(rsp_d, 0)), 64'(golden_abc(0)));

    // contention from prio 0, then 3 and 1 together
    do_reset(2);
    clear_logs();
    for (int i = 0; i < N; i++) begin want[i] = 1; wlen[i] = 2; end
    drain(100);
    want[3] = 1; wlen[3] = 2; want[1] = 1; wlen[1] = 2;
    drain(60);
    check("t3_nack", 64'(ack_i.size()), 64'd6);
    check("t3_g0", 64'(qget(ack_i, 0)), 64'd0);
    check("t3_g1", 64'(qget(ack_i, 1)), 64'd1);
    check("t3_g2", 64'(qget(ack_i, 2)), 64'd2);
    check("t3_g3", 64'(qget(ack_i, 3)), 64'd3);
    check("t3_g4", 64'(qget(ack_i, 4)), 64'd1);
    check("t3_g5", 64'(qget(ack_i, 5)), 64'd3);

    // bubbles versus continuous, len 4
    clear_logs();
    want[0] = 1; wlen[0] = 4;
    drain(40);
    d0 = qget(rsp_c, 0) - qget(ack_c, 0);
    dig0 = dget(rsp_d, 0);
    check("t4_cont_beats", 64'(beats), 64'd4);
    check("t4_cont_lat", 64'(d0), 64'd7);
    clear_logs();
    svq = '{1, 0, 0, 1, 1, 0, 1};
    want[0] = 1; wlen[0] = 4;
    drain(40);
    d1 = qget(rsp_c, 0) - qget(ack_c, 0);
    check("t4_bub_beats", 64'(beats), 64'd4);
    check("t4_bub_delay", 64'(d1 - d0), 64'd3);
    check("t4_bub_digest", 64'(dget(rsp_d, 0)), 64'(dig0));
    check("t4_golden", 64'(dig0), 64'(golden_abc(4)));

    // reset after 2 of 5 bytes
    clear_logs();
    want[1] = 1; wlen[1] = 5;
    for (int n = 0; n < 20 && acc[1] < 2; n++) tick();
    check("t5_two_bytes", 64'(acc[1]), 64'd2);
    do_reset(2);
    repeat (4) tick();
    check("t5_no_rsp", 64'(rsp_c.size()), 64'd0);
    check("t5_idle", 64'(busy), 64'd0);
    want[1] = 1; wlen[1] = 1;
    drain(40);
    check("t5_nrsp", 64'(rsp_c.size()), 64'd1);
    check("t5_digest", 64'(dget(rsp_d, 0)), 64'(golden_abc(1)));

    // back-to-back len-1 messages on requester 1
    clear_logs();
    want[1] = 1; wlen[1] = 1; rep[1] = 1;
    drain(60);
    check("t6_nrsp", 64'(rsp_c.size()), 64'd2);
    check("t6_spacing", 64'(qget(rsp_c, 1) - qget(rsp_c, 0)), 64'd5);
    check("t6_digest2", 64'(dget(rsp_d, 1)), 64'(golden_abc(1)));

    // randomized traffic
    rnd_mode = 1; spawn = 1;
    repeat (3000) tick();
    spawn = 0;
    drain(400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hash_req_arbiter.md
# hash_req_arbiter

Round-robin front-end that shares one `full_hash_des_top` hash core among `N_REQ` byte-stream requesters. It grants the core to one requester per message, forwards that requester's length and byte stream, waits for the core's `hash_ready`, then returns the 32-bit digest tagged with the requester index. It sits between the requester ports and the core, and is the only driver of the core's `M_valid`, `C_in` and `M`.

## Interface
- `N_REQ`, 4: number of requesters, 2..16.
- `ID_W`, 2: width of requester index, equal to clog2(`N_REQ`).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset, shared with the hash core.
- `req_valid` in `N_REQ`: message request per requester; held until its `req_ack`.
- `req_len` in `N_REQ`*64: message byte count per requester; slice i is bits [64i+63:64i]; 0 is legal.
- `req_ack` out `N_REQ`: one-cycle grant pulse.
- `s_data` in `N_REQ`*8: byte stream per requester.
- `s_valid` in `N_REQ`: byte valid.
- `s_ready` out `N_REQ`: byte accepted when `s_valid`&`s_ready`.
- `rsp_valid` out 1: one-cycle digest-complete pulse.
- `rsp_id` out `ID_W`: index of the requester that owns `rsp_digest`.
- `rsp_digest` out 32: digest, held until the next response.
- `busy` out 1: high in every state except IDLE.
- `core_m_valid` out 1: to core `M_valid`.
- `core_c_in` out 64: to core `C_in`.
- `core_m` out 8: to core `M`.
- `core_hash_ready` in 1: from core `hash_ready`.
- `core_digest` in 32: from core `digest_out`.

## Operation
- States: IDLE, STREAM, WAIT.
- **IDLE:** if any `req_valid` is set, pick the first requester at or after `prio` (wrapping). At the clock edge:
  - latch `gnt` and `remaining` = `req_len[gnt]`;
  - register `req_ack[gnt]`=1 for one cycle;
  - move to STREAM.
- **STREAM:**
  - `core_c_in` = latched length, held constant for the whole STREAM state.
  - `s_ready[gnt]` = (`remaining`!=0). All other `s_ready` bits are 0.
  - `core_m_valid` = `s_valid[gnt]`&`s_ready[gnt]` and `core_m` = `s_data[gnt]`, both combinational.
  - Each accepted byte decrements `remaining`. The first accepted byte is the core's init beat.
  - When the last byte is accepted, go to WAIT.
  - Gaps (`s_valid`=0) are allowed. `core_m_valid` is then 0 and the core holds.
  - **Zero length:** in the first STREAM cycle, drive `core_m_valid`=1 and `core_m`=0 for one cycle, keep `s_ready`=0, then go to WAIT.
- **WAIT:**
  - `core_m_valid`=0 and all `s_ready`=0.
  - When `core_hash_ready`=1:
    - register `rsp_digest`=`core_digest`, `rsp_id`=`gnt` and `rsp_valid`=1;
    - set `prio`=(`gnt`+1) mod `N_REQ`;
    - go to IDLE.
  - `core_hash_ready` is always 0 in the first WAIT cycle, because the core clears it at the init edge. A stale high from the previous message can never be mistaken for completion.
- `remaining` is a 64-bit down-counter. It never wraps, because decrements are gated by `remaining`!=0.
- `req_valid` or `req_len` changing on a non-granted requester has no effect. `req_len[gnt]` changing after grant is ignored.
- `core_m_valid` is never asserted in IDLE or WAIT.

## Timing
- **Reset values:**
  - state=IDLE, `prio`=0, `gnt`=0, `remaining`=0;
  - `req_ack`=0, `s_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_digest`=0;
  - `busy`=0, `core_m_valid`=0, `core_c_in`=0, `core_m`=0.
- **Reset mid-message:** everything returns to reset values immediately. The partial message is dropped and no response is produced. The core resets with the same `rst_n`.
- **Grant latency:** `req_ack` is high in the first STREAM cycle, which is one cycle after the `req_valid` is seen in IDLE.
- **Stream timing:** with `s_valid` held high, byte k is accepted in STREAM cycle t0+k.
  - The core processes the last byte at the end of t0+L.
  - Its final state is t0+L+1, and `hash_ready` rises in t0+L+2.
  - `rsp_valid` is high in t0+L+3. This holds for L=0 as well.
- **Throughput:** back-to-back messages each take L+4 cycles (IDLE 1 + STREAM L, or 1 cycle when L=0 + WAIT 3).
- **Simultaneous requests:** ties are resolved by round-robin from `prio`. A requester never waits more than `N_REQ`-1 messages.
- **New requests during STREAM/WAIT:** these wait. Arbitration happens only in IDLE.

## Test plan
- **Single message:** req 0 with len 3, bytes 0x61 0x62 0x63 and `s_valid` continuous.
  - `req_ack[0]` at cycle 1.
  - `core_m_valid` high for exactly 3 cycles with `core_c_in`=3.
  - `rsp_valid` at t0+6, `rsp_id`=0, `rsp_digest` equal to the golden-model digest.
- **Zero length:** req 2 with len 0.
  - One `core_m_valid` beat with `core_c_in`=0 and no `s_ready[2]`.
  - `rsp_valid` at t0+3, `rsp_id`=2, digest equal to the golden model.
- **Contention:** all 4 requesters raise `req_valid` at once with len 2 each.
  - Grant order 0,1,2,3.
  - Then re-request 3 and 1 together: 1 is granted first, because `prio` wrapped to 0 and 1 is the first pending index at or after it.
- **Bubbles:** len 4 with `s_valid` pattern 1,0,0,1,1,0,1.
  - Exactly 4 `core_m_valid` beats.
  - `rsp_valid` delayed by 3 cycles versus the continuous case.
  - Digest unchanged from the continuous case.
- **Reset mid-stream:** assert `rst_n`=0 after 2 of 5 bytes.
  - All outputs return to reset values.
  - No `rsp_valid`.
  - After release, a fresh len-1 message completes with the correct digest.
- **Back-to-back:** req 1 len 1 followed by req 1 len 1.
  - Two responses, 5 cycles apart.
  - The second digest matches the golden model, with no stale `hash_ready` completion.
